pkt_af_buffer: RTL
==================

Name: pkt_af_buffer

Overview:
- Receive-side packet buffer feeding from an almost_full-paced packet source.
- Accepts Avalon-ST-style packet words with no backpressure (valid only). Stores them in a FIFO and drives out_almost_full back to the source. The source stops only at a packet boundary.
- Drains to a ready/valid consumer.
- Flags overflow and framing violations, since the input side cannot be stalled.

Parameters:
- DWIDTH, 512, data word width.
- EWIDTH, 6, empty-byte field width.
- DEPTH, 64, FIFO entries, power of two, >= 4.
- AF_THRESH, 32, occupancy at or above which out_almost_full asserts. Must be <= DEPTH minus (max packet words + source pipeline depth + 2).

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  DWIDTH  packet word
- in_sop  in  1  start of packet
- in_eop  in  1  end of packet
- in_empty  in  EWIDTH  empty bytes, meaningful on eop
- in_valid  in  1  word present; no ready
- out_almost_full  out  1  pacing signal to source
- out_data  out  DWIDTH  head word
- out_sop  out  1  head sop
- out_eop  out  1  head eop
- out_empty  out  EWIDTH  head empty
- out_valid  out  1  head valid
- out_ready  in  1  consumer accepts head
- occupancy  out  $clog2(DEPTH)+1  stored words
- overflow  out  1  sticky: word dropped on full
- framing_err  out  1  sticky: sop/eop sequence violation
- drop_cnt  out  16  dropped words, saturating
- in_pkt_cnt  out  32  accepted eop words, wrapping

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, occupancy 0.
  - out_valid 0; out_sop, out_eop, out_empty 0.
  - overflow 0, framing_err 0, drop_cnt 0, in_pkt_cnt 0.
  - Framing state NO_PKT.
  - out_almost_full resets to 1 and deasserts on the first clk after release. out_data need not be reset.
- Write accept:
  - A word is accepted when in_valid=1 and registered occupancy < DEPTH.
  - A same-cycle pop does not free space for that write. Full means full at cycle start.
- Drop:
  - On in_valid=1 with occupancy==DEPTH, the word is discarded.
  - overflow is set; drop_cnt increments and saturates at 16'hFFFF.
  - Output framing after an overflow is not guaranteed.
- Pop: out_valid & out_ready. out_* must hold stable while out_valid=1 and out_ready=0.
- Latency:
  - A word written in cycle t into an empty buffer appears on out_* with out_valid=1 in cycle t+1 (show-ahead head register).
  - Sustained throughput is 1 word/cycle in and out.
- Occupancy:
  - occupancy <= occupancy + accept - pop. It counts the head register.
  - Never exceeds DEPTH; never underflows.
- out_almost_full: registered, equal to (next occupancy >= AF_THRESH). So it reflects a write or pop one cycle later.
- Framing state machine:
  - Advances on every in_valid word, accepted or dropped.
  - NO_PKT:
    - sop&eop: stay in NO_PKT.
    - sop only: go to IN_PKT.
    - no sop: set framing_err, stay in NO_PKT.
  - IN_PKT:
    - sop: set framing_err, stay in IN_PKT.
    - eop: go to NO_PKT.
  - Framing errors do not alter stored data.
- in_pkt_cnt: increments on accepted words with in_eop=1.
- Sticky flags clear only on reset.

Decomposition:
- Package pkt_af_pkg holds:
  - pkt_word_t: struct of data, sop, eop, empty, sized by parameters via macro or local typedef.
  - framing_state_t enum: NO_PKT, IN_PKT.
- Sub-module pkt_af_ram: simple dual-port DEPTH x (DWIDTH+EWIDTH+2) storage with registered read.
- Top holds the pointers, head register/prefetch, counters and framing FSM.

Test Plan:
- Single 4-word packet (sop on word 0, eop+empty=5 on word 3) with out_ready=1 → identical words emerge from cycle t+1. in_pkt_cnt=1; occupancy returns to 0; no flags.
- out_ready=0, DEPTH=64, AF_THRESH=32, 32 words written back-to-back → out_almost_full=1 in the cycle after the 32nd write. It drops after pops take occupancy to 31.
- out_ready=0, 66 contiguous valid words → occupancy 64, overflow=1, drop_cnt=2. The first 64 words are drained intact after out_ready=1.
- At occupancy==DEPTH, simultaneous write and pop → write dropped, occupancy 63, drop_cnt+1.
- Input sop,data,sop,eop sequence → framing_err=1 at the second sop; all 4 words stored; in_pkt_cnt=1.
- Reset asserted mid-packet with 10 words stored → all outputs at reset values immediately, out_almost_full=1. After release, a fresh packet passes cleanly with no framing_err.

Source files
------------

// File: rtl/pkt_af_pkg.sv
// ------------------------------------------------------------------
// pkt_af_pkg : shared types for the almost_full-paced packet buffer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package pkt_af_pkg;

  localparam int PKT_DWIDTH = 512;
  localparam int PKT_EWIDTH = 6;

  // Default-sized word; parameterised instances declare a local equivalent.
  typedef struct packed {
    logic [PKT_DWIDTH-1:0] data;
    logic                  sop;
    logic                  eop;
    logic [PKT_EWIDTH-1:0] empty;
  } pkt_word_t;

  typedef enum logic [0:0] {
    NO_PKT = 1'b0,
    IN_PKT = 1'b1
  } framing_state_t;

endpackage

`default_nettype wire

// File: rtl/pkt_af_ram.sv
// ------------------------------------------------------------------
// pkt_af_ram : simple dual-port storage, registered read every cycle
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pkt_af_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 520
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
    rd_data <= r_mem[rd_addr];
  end

endmodule

`default_nettype wire

// File: rtl/pkt_af_buffer.sv
// ------------------------------------------------------------------
// pkt_af_buffer : non-backpressured packet FIFO with almost_full pacing
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module pkt_af_buffer
  import pkt_af_pkg::*;
#(
  parameter int DWIDTH    = 512,
  parameter int EWIDTH    = 6,
  parameter int DEPTH     = 64,
  parameter int AF_THRESH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DWIDTH-1:0]          in_data,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [EWIDTH-1:0]          in_empty,
  input  logic                       in_valid,
  output logic                       out_almost_full,
  output logic [DWIDTH-1:0]          out_data,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [EWIDTH-1:0]          out_empty,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic                       framing_err,
  output logic [15:0]                drop_cnt,
  output logic [31:0]                in_pkt_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DWIDTH + EWIDTH + 2;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              sop;
    logic              eop;
    logic [EWIDTH-1:0] empty;
  } word_t;

  logic [CW-1:0]  r_count;
  logic [CW-1:0]  w_count_nxt;
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW-1:0]  w_rd_addr;
  logic           w_full;
  logic           w_accept;
  logic           w_drop;
  logic           w_pop;
  logic           r_byp_sel;
  word_t          r_byp_word;
  word_t          w_in_word;
  word_t          w_ram_q;
  word_t          w_head;
  framing_state_t r_fstate;
  framing_state_t w_fstate_nxt;
  logic           w_ferr_set;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_accept    = in_valid & ~w_full;
  assign w_drop      = in_valid & w_full;
  assign out_valid   = (r_count != '0);
  assign w_pop       = out_valid & out_ready;
  assign w_count_nxt = r_count + CW'(w_accept) - CW'(w_pop);
  assign occupancy   = r_count;

  // Every stored word, head included, lives in the RAM; the read port always
  // fetches the slot that will be the head next cycle.
  assign w_rd_addr = r_rptr + AW'(w_pop);
  assign w_in_word = '{data: in_data, sop: in_sop, eop: in_eop, empty: in_empty};

  pkt_af_ram #(
    .DEPTH (DEPTH),
    .WIDTH (WW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (w_accept),
    .wr_addr (r_wptr),
    .wr_data (w_in_word),
    .rd_addr (w_rd_addr),
    .rd_data (w_ram_q)
  );

  // A write into the slot being read can only happen when that word becomes
  // the head, so forward it to meet the one-cycle show-ahead latency.
  always_ff @(posedge clk) begin
    r_byp_word <= w_in_word;
  end

  assign w_head    = r_byp_sel ? r_byp_word : w_ram_q;
  assign out_data  = w_head.data;
  assign out_sop   = out_valid & w_head.sop;
  assign out_eop   = out_valid & w_head.eop;
  assign out_empty = out_valid ? w_head.empty : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count         <= '0;
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_byp_sel       <= 1'b0;
      out_almost_full <= 1'b1;
      overflow        <= 1'b0;
      framing_err     <= 1'b0;
      drop_cnt        <= '0;
      in_pkt_cnt      <= '0;
      r_fstate        <= NO_PKT;
    end else begin
      r_count         <= w_count_nxt;
      r_rptr          <= w_rd_addr;
      r_byp_sel       <= w_accept && (r_wptr == w_rd_addr);
      out_almost_full <= (w_count_nxt >= CW'(AF_THRESH));
      r_fstate        <= w_fstate_nxt;
      if (w_accept) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
      if (w_accept && in_eop) begin
        in_pkt_cnt <= in_pkt_cnt + 32'd1;
      end
      if (w_ferr_set) begin
        framing_err <= 1'b1;
      end
    end
  end

  // Framing tracks every presented word, including dropped ones.
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_ferr_set   = 1'b0;
    if (in_valid) begin
      case (r_fstate)
        NO_PKT: begin
          if (!in_sop) begin
            w_ferr_set = 1'b1;
          end else if (!in_eop) begin
            w_fstate_nxt = IN_PKT;
          end
        end
        IN_PKT: begin
          if (in_sop) begin
            w_ferr_set = 1'b1;
          end else if (in_eop) begin
            w_fstate_nxt = NO_PKT;
          end
        end
        default: w_fstate_nxt = NO_PKT;
      endcase
    end
  end

endmodule

`default_nettype wire
